// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: next-PC select codes and fetch FSM states shared by the fetch stage and control decode.
package pc_fetch_unit_pkg;
   typedef enum logic [1:0] {
      NPC_SEQ  = 2'b00,
      NPC_BR   = 2'b01,
      NPC_JAL  = 2'b10,
      NPC_JALR = 2'b11
   } npc_op_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STEP  = 2'b01,
      ST_HALT  = 2'b10,
      ST_FAULT = 2'b11
   } state_e;

   function automatic logic is_active(input state_e s);
      return (s == ST_RUN) || (s == ST_STEP);
   endfunction
endpackage

// File: rtl/pc_fetch_unit_trace_buf.sv
// pc_trace_buf: ring buffer of the most recent retired PCs; rd_idx 0 returns the newest entry.
module pc_trace_buf #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            wr_en,
   input  logic [XLEN-1:0] wr_data,
   input  logic [IW-1:0]   rd_idx,
   output logic [XLEN-1:0] rd_data
);
   logic [XLEN-1:0] r_mem [DEPTH];
   logic [IW-1:0]   r_wptr;
   logic [IW-1:0]   w_rd_ptr;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr <= '0;
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      end else if (wr_en) begin
         r_mem[r_wptr] <= wr_data;
         r_wptr        <= r_wptr + 1'b1;
      end
   end

   // write pointer sits one past the newest entry
   assign w_rd_ptr = r_wptr - rd_idx - 1'b1;
   assign rd_data  = r_mem[w_rd_ptr];
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: RV32 fetch stage - PC register, next-PC select, run/step/halt/fault control.
// Optional PC history buffer enabled by `PC_TRACE_EN.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned ADDR_W      = 6,
   parameter int unsigned RESET_PC    = 0,
   parameter int unsigned LAST_IDX    = 12,
   parameter int unsigned HALT_ON_END = 1,
   parameter int unsigned TRACE_DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           cpu_en,
   input  logic                           run_mode,
   input  logic                           step_req,
   input  logic [1:0]                     npc_op,
   input  logic                           br_taken,
   input  logic [XLEN-1:0]                imm,
   input  logic [XLEN-1:0]                rs1_val,
   output logic [XLEN-1:0]                pc_o,
   output logic [XLEN-1:0]                pc_plus4_o,
   output logic [ADDR_W-1:0]              rom_addr_o,
   output logic                           retire_o,
   output logic                           halted_o,
   output logic                           misalign_o,
   input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
   output logic [XLEN-1:0]                trace_pc
);
   localparam logic [XLEN-1:0]   L_RST_PC  = XLEN'(RESET_PC);
   localparam logic [ADDR_W-1:0] L_LAST    = ADDR_W'(LAST_IDX);
   localparam logic              L_HALT_EN = HALT_ON_END != 0;

   logic [XLEN-1:0] r_pc;
   state_e          r_state;
   logic            r_step_q;
   logic            r_step_pend;
   logic            r_retire;
   logic [XLEN-1:0] w_seq;
   logic [XLEN-1:0] w_rel;
   logic [XLEN-1:0] w_jalr;
   logic [XLEN-1:0] w_target;
   logic            w_take_rel;
   logic            w_step_edge;
   logic            w_mode_chg;
   logic            w_adv;
   logic            w_fault;
   logic            w_end;
   logic            w_ret;

   assign w_seq      = r_pc + XLEN'(4);
   assign w_rel      = r_pc + imm;
   assign w_jalr     = (rs1_val + imm) & ~XLEN'(1);
   assign w_take_rel = (npc_op == NPC_JAL) || ((npc_op == NPC_BR) && br_taken);
   assign w_target   = (npc_op == NPC_JALR) ? w_jalr : w_take_rel ? w_rel : w_seq;

   assign w_fault = w_target[1];
   // past the last ROM word, or beyond the ROM address space entirely
   assign w_end   = (w_target[ADDR_W+1:2] > L_LAST) || (|w_target[XLEN-1:ADDR_W+2]);

   assign w_step_edge = step_req & ~r_step_q;
   assign w_mode_chg  = is_active(r_state) && ((r_state == ST_RUN) != run_mode);
   assign w_adv       = cpu_en && ((r_state == ST_RUN) || ((r_state == ST_STEP) && r_step_pend));
   assign w_ret       = w_adv && !w_fault && (!w_end || !L_HALT_EN);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pc        <= L_RST_PC;
         r_state     <= run_mode ? ST_RUN : ST_STEP;
         r_step_q    <= 1'b0;
         r_step_pend <= 1'b0;
         r_retire    <= 1'b0;
      end else begin
         r_step_q    <= step_req;
         r_retire    <= w_ret;
         r_step_pend <= !w_mode_chg && ((r_step_pend && !w_adv) || w_step_edge);
         if (w_ret) r_pc <= w_end ? L_RST_PC : w_target;
         if (w_adv && w_fault) r_state <= ST_FAULT;
         else if (w_adv && w_end && L_HALT_EN) r_state <= ST_HALT;
         else if (is_active(r_state)) r_state <= run_mode ? ST_RUN : ST_STEP;
      end
   end

   assign pc_o       = r_pc;
   assign pc_plus4_o = w_seq;
   assign rom_addr_o = r_pc[ADDR_W+1:2];
   assign retire_o   = r_retire;
   assign halted_o   = r_state == ST_HALT;
   assign misalign_o = r_state == ST_FAULT;

`ifdef PC_TRACE_EN
   pc_trace_buf #(
      .XLEN  (XLEN),
      .DEPTH (TRACE_DEPTH)
   ) u_trace (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (w_ret),
      .wr_data (r_pc),
      .rd_idx  (trace_idx),
      .rd_data (trace_pc)
   );
`else
   logic w_unused_trace;
   assign w_unused_trace = ^trace_idx;
   assign trace_pc       = '0;
`endif
endmodule
